// File: rtl/weight_pkg.sv
// weight_pkg: definitions shared by the weight loader, the weight storage and
// future readers of the weight array.
//   loader_state_t : loader FSM states
//   DATA_SIZE      : width of one signed weight word
//   SIZE           : words per row and rows per layer
//   LAYER_SIZE     : number of layers
//   idx_bits()     : width of an index counting 0..n-1 (at least 1 bit)
package weight_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } loader_state_t;

  localparam int DATA_SIZE  = 16;
  localparam int SIZE       = 3;
  localparam int LAYER_SIZE = 5;

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/weight_loader_if.sv
// weight_loader_if: word stream into the loader plus the storage write port.
//   in_data/in_valid/in_ready : word stream. A word moves on a rising clk edge
//     where in_valid and in_ready are both high. The source holds in_data
//     stable while in_valid is high and in_ready is low; in_ready never
//     depends combinationally on in_valid.
//   write_layer_index, write_row_index, write_data, is_write : storage write
//     port. is_write is a one-cycle strobe; storage captures on negedge.
// modport master : the word source / storage side
// modport slave  : the loader
interface weight_loader_if #(
  parameter int data_size = weight_pkg::DATA_SIZE,
  parameter int size      = weight_pkg::SIZE
) ();
  logic [data_size-1:0]      in_data;
  logic                      in_valid;
  logic                      in_ready;
  logic [31:0]               write_layer_index;
  logic [31:0]               write_row_index;
  logic [data_size*size-1:0] write_data;
  logic                      is_write;

  modport master (
    output in_data, in_valid,
    input  in_ready, write_layer_index, write_row_index, write_data, is_write
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, write_layer_index, write_row_index, write_data, is_write
  );
endinterface

// File: rtl/row_packer.sv
// row_packer: holds one row of weight words and produces the packed row.
//   clk, rst    : clock, synchronous active-high reset (clears all words)
//   load_en     : store word at column col this cycle
//   col         : column index 0..size-1
//   word        : weight word to store
//   capture     : latch the packed row (including a word loaded this cycle)
//   packed_data : registered packed row, column 0 in the MSB slice
module row_packer
  import weight_pkg::*;
#(
  parameter int data_size = DATA_SIZE,
  parameter int size      = SIZE,
  localparam int COL_W    = idx_bits(size)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_en,
  input  logic [COL_W-1:0]          col,
  input  logic [data_size-1:0]      word,
  input  logic                      capture,
  output logic [data_size*size-1:0] packed_data
);

  logic [data_size-1:0]      words_q [size];
  logic [data_size-1:0]      words_d [size];
  logic [data_size*size-1:0] packed_d;

  // The packed view includes the word being loaded now, so the row can be
  // captured on the same edge that accepts its last word.
  always_comb begin
    words_d  = words_q;
    packed_d = '0;
    if (load_en && (int'(col) < size)) words_d[col] = word;
    for (int i = 0; i < size; i++) begin
      packed_d[(size-i)*data_size-1 -: data_size] = words_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      words_q     <= '{default: '0};
      packed_data <= '0;
    end else begin
      words_q <= words_d;
      if (capture) packed_data <= packed_d;
    end
  end

endmodule

// File: rtl/weight_loader.sv
// weight_loader: streams size*size*layer_size weight words into the weight
// storage, one packed row per write, walking layers and rows row-major.
//   clk, rst  : clock, synchronous active-high reset
//   start     : begin a full load (only honoured in IDLE)
//   bus       : word stream in, storage write port out (slave side)
//   busy      : high in every state except IDLE
//   done      : one-cycle pulse after the last row write
//   state_dbg : current FSM state
// All outputs are flops; they are loaded from the next-state decode so they
// line up with the state register.
module weight_loader
  import weight_pkg::*;
#(
  parameter int data_size  = DATA_SIZE,
  parameter int size       = SIZE,
  parameter int layer_size = LAYER_SIZE,
  localparam int WORD_W    = idx_bits(size)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  weight_loader_if.slave  bus,
  output logic            busy,
  output logic            done,
  output loader_state_t   state_dbg
);

  loader_state_t state_q, state_d;
  logic [31:0]       layer_q, row_q;
  logic [WORD_W-1:0] word_q;
  logic              accept, last_word, last_row;

  assign accept    = bus.in_valid & bus.in_ready;
  assign last_word = accept && (word_q == WORD_W'(size - 1));
  assign last_row  = (layer_q == 32'(layer_size - 1)) && (row_q == 32'(size - 1));
  assign state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = COLLECT;
      COLLECT: if (last_word) state_d = WRITE;
      WRITE:   state_d = last_row ? DONE : COLLECT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      layer_q <= '0;
      row_q   <= '0;
      word_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            layer_q <= '0;
            row_q   <= '0;
            word_q  <= '0;
          end
        end
        COLLECT: if (accept) word_q <= word_q + WORD_W'(1);
        WRITE: begin
          word_q <= '0;
          if (row_q == 32'(size - 1)) begin
            row_q   <= '0;
            layer_q <= layer_q + 32'd1;
          end else begin
            row_q <= row_q + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.in_ready          <= 1'b0;
      bus.is_write          <= 1'b0;
      bus.write_layer_index <= '0;
      bus.write_row_index   <= '0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
    end else begin
      bus.in_ready <= (state_d == COLLECT);
      bus.is_write <= (state_d == WRITE);
      busy         <= (state_d != IDLE);
      done         <= (state_d == DONE);
      // Target indices move only when a row enters WRITE.
      if (last_word) begin
        bus.write_layer_index <= layer_q;
        bus.write_row_index   <= row_q;
      end
    end
  end

  row_packer #(
    .data_size(data_size),
    .size     (size)
  ) u_row_packer (
    .clk        (clk),
    .rst        (rst),
    .load_en    (accept),
    .col        (word_q),
    .word       (bus.in_data),
    .capture    (last_word),
    .packed_data(bus.write_data)
  );

endmodule

// File: tb/tb_weight_loader.sv
module tb_weight_loader;
  import weight_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done;
  loader_state_t state_dbg;

  weight_loader_if #(.data_size(16), .size(3)) bus ();

  weight_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // monitor / scoreboard capture of storage writes
  logic [47:0] wr_data_q[$];
  int          wr_layer_q[$];
  int          wr_row_q[$];
  int          done_count = 0;
  int          overlap_errs = 0;
  int          ready_errs = 0;
  logic [15:0] stim_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.is_write === 1'b1) begin
      wr_data_q.push_back(bus.write_data);
      wr_layer_q.push_back(int'(bus.write_layer_index));
      wr_row_q.push_back(int'(bus.write_row_index));
    end
    if (done === 1'b1) done_count++;
    if (done === 1'b1 && bus.is_write === 1'b1) overlap_errs++;
    if (busy === 1'b1 && bus.in_ready !== ~(bus.is_write | done)) ready_errs++;
    if (busy !== 1'b1 && bus.in_ready !== 1'b0) ready_errs++;
  end

  task automatic clear_monitor();
    wr_data_q.delete();
    wr_layer_q.delete();
    wr_row_q.delete();
    done_count = 0;
    overlap_errs = 0;
    ready_errs = 0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1 rst = 1'b1;
    bus.in_valid = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic do_start(output int t0);
    @(posedge clk); #1 start = 1'b1;
    @(negedge clk); t0 = cyc;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Presents stim_q in order, holding each word until accepted. With gap set,
  // in_valid drops for one cycle after each accepted word. start is raised
  // while word index pulse_a or pulse_b is being presented.
  task automatic drive_stream(input bit gap, input int pulse_a, input int pulse_b, output bit ok);
    int  acc = 0;
    int  budget = 0;
    bit  got;
    ok = 1'b1;
    while (acc < stim_q.size()) begin
      bus.in_valid = 1'b1;
      bus.in_data  = stim_q[acc];
      start = (acc == pulse_a) || (acc == pulse_b);
      @(negedge clk); got = bus.in_ready;
      @(posedge clk); #1;
      if (got) begin
        acc++;
        if (gap) begin
          bus.in_valid = 1'b0;
          start = 1'b0;
          @(posedge clk); #1;
        end
      end
      budget++;
      if (budget > 600) begin
        ok = 1'b0;
        break;
      end
    end
    bus.in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok, output int dcyc);
    ok = 1'b0;
    dcyc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        dcyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.is_write, busy, done} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got %b need 0000", {bus.in_ready, bus.is_write, busy, done});
    end
    checks++;
    if (bus.write_layer_index !== 32'd0 || bus.write_row_index !== 32'd0 || bus.write_data !== 48'd0) begin
      errors++;
      $display("FAIL reset_write_port got %0d/%0d/%h need 0/0/0",
               bus.write_layer_index, bus.write_row_index, bus.write_data);
    end
    checks++;
    if (state_dbg !== IDLE) begin
      errors++;
      $display("FAIL reset_state got %0d need IDLE", state_dbg);
    end
  endtask

  task automatic test_full_load();
    int t0, dcyc;
    bit ok, dok;
    logic [47:0] exp;
    stim_q.delete();
    for (int i = 1; i <= 45; i++) stim_q.push_back(16'(i));
    clear_monitor();
    do_start(t0);
    drive_stream(1'b0, -1, -1, ok);
    wait_done(dok, dcyc);
    @(negedge clk);
    checks++;
    if (!ok || !dok) begin
      errors++;
      $display("FAIL full_timeout got stream=%0d done=%0d need 1/1", ok, dok);
    end
    checks++;
    if (dcyc - t0 !== 61) begin
      errors++;
      $display("FAIL full_latency got %0d need 61", dcyc - t0);
    end
    checks++;
    if (wr_data_q.size() !== 15) begin
      errors++;
      $display("FAIL full_write_count got %0d need 15", wr_data_q.size());
    end else begin
      checks++;
      if (wr_data_q[0] !== {16'd1, 16'd2, 16'd3} || wr_layer_q[0] !== 0 || wr_row_q[0] !== 0) begin
        errors++;
        $display("FAIL full_first got L%0d R%0d %h need L0 R0 000100020003", wr_layer_q[0], wr_row_q[0], wr_data_q[0]);
      end
      checks++;
      if (wr_data_q[5] !== {16'd16, 16'd17, 16'd18} || wr_layer_q[5] !== 1 || wr_row_q[5] !== 2) begin
        errors++;
        $display("FAIL full_sixth got L%0d R%0d %h need L1 R2 001000110012", wr_layer_q[5], wr_row_q[5], wr_data_q[5]);
      end
      checks++;
      if (wr_data_q[14] !== {16'd43, 16'd44, 16'd45} || wr_layer_q[14] !== 4 || wr_row_q[14] !== 2) begin
        errors++;
        $display("FAIL full_last got L%0d R%0d %h need L4 R2 002b002c002d", wr_layer_q[14], wr_row_q[14], wr_data_q[14]);
      end
      for (int k = 0; k < 15; k++) begin
        exp = {16'(3*k+1), 16'(3*k+2), 16'(3*k+3)};
        checks++;
        if (wr_data_q[k] !== exp || wr_layer_q[k] !== k/3 || wr_row_q[k] !== k%3) begin
          errors++;
          $display("FAIL full_row%0d got L%0d R%0d %h need L%0d R%0d %h",
                   k, wr_layer_q[k], wr_row_q[k], wr_data_q[k], k/3, k%3, exp);
        end
      end
    end
    checks++;
    if (done_count !== 1 || overlap_errs !== 0) begin
      errors++;
      $display("FAIL full_done_pulse got count=%0d overlap=%0d need 1/0", done_count, overlap_errs);
    end
    checks++;
    if (busy !== 1'b0 || state_dbg !== IDLE) begin
      errors++;
      $display("FAIL full_idle_after_done got busy=%b state=%0d need 0/IDLE", busy, state_dbg);
    end
    checks++;
    if (bus.write_layer_index !== 32'd4 || bus.write_row_index !== 32'd2 || bus.write_data !== {16'd43, 16'd44, 16'd45}) begin
      errors++;
      $display("FAIL full_hold got %0d/%0d/%h need 4/2/002b002c002d",
               bus.write_layer_index, bus.write_row_index, bus.write_data);
    end
  endtask

  task automatic test_backpressure();
    int t0, dcyc;
    bit ok, dok;
    logic [47:0] exp;
    stim_q.delete();
    for (int i = 1; i <= 45; i++) stim_q.push_back(16'(i));
    clear_monitor();
    do_start(t0);
    drive_stream(1'b1, -1, -1, ok);
    wait_done(dok, dcyc);
    @(negedge clk);
    checks++;
    if (!ok || !dok || wr_data_q.size() !== 15) begin
      errors++;
      $display("FAIL bp_count got stream=%0d done=%0d writes=%0d need 1/1/15", ok, dok, wr_data_q.size());
    end else begin
      for (int k = 0; k < 15; k++) begin
        exp = {16'(3*k+1), 16'(3*k+2), 16'(3*k+3)};
        checks++;
        if (wr_data_q[k] !== exp || wr_layer_q[k] !== k/3 || wr_row_q[k] !== k%3) begin
          errors++;
          $display("FAIL bp_row%0d got L%0d R%0d %h need L%0d R%0d %h",
                   k, wr_layer_q[k], wr_row_q[k], wr_data_q[k], k/3, k%3, exp);
        end
      end
    end
    checks++;
    if (ready_errs !== 0) begin
      errors++;
      $display("FAIL bp_in_ready got %0d bad cycles need 0", ready_errs);
    end
  endtask

  task automatic test_sign();
    int t0;
    bit ok;
    apply_reset();
    stim_q.delete();
    stim_q.push_back(16'hFFFF);
    stim_q.push_back(16'h8000);
    stim_q.push_back(16'h7FFF);
    clear_monitor();
    do_start(t0);
    drive_stream(1'b0, -1, -1, ok);
    repeat (2) @(negedge clk);
    checks++;
    if (!ok || wr_data_q.size() !== 1) begin
      errors++;
      $display("FAIL sign_count got stream=%0d writes=%0d need 1/1", ok, wr_data_q.size());
    end else if (wr_data_q[0] !== 48'hFFFF_8000_7FFF) begin
      errors++;
      $display("FAIL sign_data got %h need ffff80007fff", wr_data_q[0]);
    end
    apply_reset();
  endtask

  task automatic test_start_ignored();
    int t0, dcyc;
    bit ok, dok;
    stim_q.delete();
    for (int i = 1; i <= 45; i++) stim_q.push_back(16'(i));
    clear_monitor();
    do_start(t0);
    // index 1 is presented in COLLECT, index 3 first in the WRITE cycle
    drive_stream(1'b0, 1, 3, ok);
    wait_done(dok, dcyc);
    @(negedge clk);
    checks++;
    if (!ok || !dok || wr_data_q.size() !== 15) begin
      errors++;
      $display("FAIL start_ignored_count got stream=%0d done=%0d writes=%0d need 1/1/15", ok, dok, wr_data_q.size());
    end else begin
      checks++;
      if (wr_data_q[1] !== {16'd4, 16'd5, 16'd6} || wr_layer_q[1] !== 0 || wr_row_q[1] !== 1) begin
        errors++;
        $display("FAIL start_ignored_row1 got L%0d R%0d %h need L0 R1 000400050006", wr_layer_q[1], wr_row_q[1], wr_data_q[1]);
      end
      checks++;
      if (wr_data_q[14] !== {16'd43, 16'd44, 16'd45} || wr_layer_q[14] !== 4 || wr_row_q[14] !== 2) begin
        errors++;
        $display("FAIL start_ignored_last got L%0d R%0d %h need L4 R2 002b002c002d", wr_layer_q[14], wr_row_q[14], wr_data_q[14]);
      end
    end
  endtask

  task automatic test_reset_midload();
    int t0;
    bit ok;
    stim_q.delete();
    for (int i = 1; i <= 20; i++) stim_q.push_back(16'(i));
    clear_monitor();
    do_start(t0);
    drive_stream(1'b0, -1, -1, ok);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (!ok || {bus.in_ready, bus.is_write, busy, done} !== 4'b0 || bus.write_data !== 48'd0 ||
        bus.write_layer_index !== 32'd0 || bus.write_row_index !== 32'd0) begin
      errors++;
      $display("FAIL midreset_outputs got ok=%0d flags=%b %0d/%0d/%h need 1 0000 0/0/0",
               ok, {bus.in_ready, bus.is_write, busy, done},
               bus.write_layer_index, bus.write_row_index, bus.write_data);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (wr_data_q.size() !== 6) begin
      errors++;
      $display("FAIL midreset_writes got %0d need 6", wr_data_q.size());
    end
    stim_q.delete();
    stim_q.push_back(16'd201);
    stim_q.push_back(16'd202);
    stim_q.push_back(16'd203);
    clear_monitor();
    do_start(t0);
    drive_stream(1'b0, -1, -1, ok);
    repeat (2) @(negedge clk);
    checks++;
    if (!ok || wr_data_q.size() !== 1) begin
      errors++;
      $display("FAIL midreset_restart_count got stream=%0d writes=%0d need 1/1", ok, wr_data_q.size());
    end else if (wr_data_q[0] !== {16'd201, 16'd202, 16'd203} || wr_layer_q[0] !== 0 || wr_row_q[0] !== 0) begin
      errors++;
      $display("FAIL midreset_restart got L%0d R%0d %h need L0 R0 00c900ca00cb", wr_layer_q[0], wr_row_q[0], wr_data_q[0]);
    end
    apply_reset();
  endtask

  task automatic test_idle_valid();
    int t0;
    bit ok;
    clear_monitor();
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'd7;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0 || wr_data_q.size() !== 0) begin
      errors++;
      $display("FAIL idle_valid got ready=%b writes=%0d need 0/0", bus.in_ready, wr_data_q.size());
    end
    do_start(t0);
    stim_q.delete();
    stim_q.push_back(16'd9);
    stim_q.push_back(16'd10);
    stim_q.push_back(16'd11);
    drive_stream(1'b0, -1, -1, ok);
    repeat (2) @(negedge clk);
    checks++;
    if (!ok || wr_data_q.size() !== 1) begin
      errors++;
      $display("FAIL idle_valid_count got stream=%0d writes=%0d need 1/1", ok, wr_data_q.size());
    end else if (wr_data_q[0] !== {16'd9, 16'd10, 16'd11}) begin
      errors++;
      $display("FAIL idle_valid_first got %h need 0009000a000b", wr_data_q[0]);
    end
    apply_reset();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    test_reset();
    test_full_load();
    test_backpressure();
    test_sign();
    test_start_ignored();
    test_reset_midload();
    test_idle_valid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
